axi_sram_ctrl128: RTL and testbench
===================================

Name: axi_sram_ctrl128

Overview:
AXI4 slave front end that drives one 128-bit single-port SRAM macro (16384 x 128, active-low CEN, per-byte active-low WEN, 1-cycle registered read data Q). It converts AXI write and read bursts into SRAM accesses, arbitrates the shared port, and generates the B and R responses. It sits between the SoC AXI interconnect and the on-chip memory macro.

Parameters:
AXI_AW, 40, AXI address width
ID_W, 4, AXI ID width
SRAM_AW, 14, SRAM word-address width; word = 16 bytes

Ports:
CLK  in  1  clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
awid/awaddr/awlen/awburst  in  ID_W/AXI_AW/8/2  write address channel
awvalid in 1; awready out 1  AW handshake
wdata/wstrb/wlast  in  128/16/1  write data channel
wvalid in 1; wready out 1  W handshake
bid/bresp  out  ID_W/2  write response
bvalid out 1; bready in 1  B handshake
arid/araddr/arlen/arburst  in  ID_W/AXI_AW/8/2  read address channel
arvalid in 1; arready out 1  AR handshake
rid/rdata/rresp/rlast  out  ID_W/128/2/1  read data channel
rvalid out 1; rready in 1  R handshake
sram_a  out  SRAM_AW  SRAM word address
sram_cen  out  1  SRAM chip enable, active low
sram_wen  out  16  SRAM byte write enables, active low
sram_d  out  128  SRAM write data
sram_q  in  128  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Reset values: awready=arready=wready=bvalid=rvalid=rlast=0; bresp=rresp=0; bid=rid=0; sram_cen=1; sram_wen=16'hFFFF; state IDLE; priority flag = write.
- One transaction at a time. States: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE: awready/arready are combinational grants. Only AW pending -> write; only AR pending -> read; both pending -> the side not granted last time wins (round-robin, write first after reset). Only the winner's ready is high. On the grant, latch id, len and burst, and latch addr[SRAM_AW+3:4] as the word address. Go to WR_DATA, or issue the first SRAM read and go to RD_DATA.
- Word address: byte address bits [3:0] and bits above SRAM_AW+3 are ignored. Size is always full 128-bit; narrow writes use wstrb.
- Address step: INCR and WRAP (WRAP treated as INCR) step +1 per beat, modulo 2^SRAM_AW (wraps at top of macro). FIXED holds the address.
- WR_DATA: wready=1.
  - Each cycle with wvalid: sram_cen=0, sram_wen=~wstrb, sram_d=wdata, sram_a=current address.
  - A beat with wstrb=0 drives cen=0 with wen all ones, which is a harmless SRAM read.
  - Beats are counted against the latched len; wlast is ignored.
  - After beat len+1, go to WR_RESP. No idle cycle is needed between beats.
- WR_RESP: bvalid=1, bid=latched id, bresp=OKAY. On bready, go to IDLE. Earliest new AW grant is the cycle after the B handshake.
- RD_DATA:
  - rdata is driven directly from sram_q. The SRAM holds Q until the next read.
  - rvalid rises the cycle after the first read strobe.
  - On each R handshake with beats remaining, issue the next read in the same cycle, so rvalid stays high. This gives full throughput: 1 beat/cycle with rready held high.
  - While rready=0, cen stays 1 and rdata is stable.
  - rlast=1 only on beat len+1. On that handshake, rvalid falls next cycle and the state returns to IDLE.
  - rid = latched id; rresp = OKAY.
- sram_cen=1 whenever no access is issued; sram_wen=16'hFFFF on every read.
- Latency: AR grant at cycle t -> first rvalid at t+1. AW grant at t -> earliest write strobe at t+1 -> bvalid the cycle after the last beat.
- Reset mid-burst: immediate return to reset values. The partial burst is abandoned, with no response.
- No error responses are generated.

Test Plan:
- Single write, addr 0x40, len 0, wstrb 0xFFFF, data D0 -> sram_a=4, cen=0, wen=0x0000 for one cycle; then bvalid, bresp=0, bid=awid.
- INCR write, len 3, addr 0x3FFF0 -> sram_a 0x3FFF, 0x0000, 0x0001, 0x0002 (wrap). Read back with arlen 3 -> same 4 words with rlast on beat 4 only.
- Read len 7, rready toggled 1/0 -> 8 beats in order. rdata stable and cen=1 while stalled. Back-to-back beats when rready=1.
- wstrb=0x000F over a preloaded word -> only bytes 0-3 change on read-back.
- awvalid and arvalid asserted together twice -> first grant write, second grant read.
- RST_N pulsed low mid read burst -> all outputs at reset values during reset. A fresh transaction afterwards completes normally.

Source files
------------

// File: rtl/axi_sram_ctrl128.sv
// AXI4 slave front end for a 16384 x 128 single-port SRAM macro.
// Serves one burst at a time and arbitrates AW/AR round-robin when both are pending.
module axi_sram_ctrl128 #(
    parameter int unsigned AXI_AW  = 40,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned SRAM_AW = 14
) (
    input  logic                CLK,
    input  logic                RST_N,
    // write address channel
    input  logic [ID_W-1:0]     awid,
    input  logic [AXI_AW-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data channel
    input  logic [127:0]        wdata,
    input  logic [15:0]         wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response channel
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    // read address channel
    input  logic [ID_W-1:0]     arid,
    input  logic [AXI_AW-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    // read data channel
    output logic [ID_W-1:0]     rid,
    output logic [127:0]        rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    // SRAM macro port
    output logic [SRAM_AW-1:0]  sram_a,
    output logic                sram_cen,
    output logic [15:0]         sram_wen,
    output logic [127:0]        sram_d,
    input  logic [127:0]        sram_q
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 8;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      id_q, id_nxt;
    logic [LEN_W-1:0]     len_q, len_nxt;
    logic [LEN_W-1:0]     beat_q, beat_nxt;
    logic                 fixed_q, fixed_nxt;
    logic [SRAM_AW-1:0]   addr_q, addr_nxt;
    logic                 prio_rd_q, prio_rd_nxt;

    logic [SRAM_AW-1:0]   addr_step;
    logic [SRAM_AW-1:0]   aw_word;
    logic [SRAM_AW-1:0]   ar_word;
    logic                 aw_win;
    logic                 ar_win;
    logic                 last_beat;
    logic                 unused_bits;

    // Only the word-index bits of the byte address select an SRAM row.
    assign aw_word   = awaddr[SRAM_AW+3:4];
    assign ar_word   = araddr[SRAM_AW+3:4];
    assign addr_step = fixed_q ? addr_q : addr_q + SRAM_AW'(1);
    assign last_beat = (beat_q == len_q);

    // prio_rd_q set means the previous grant went to the write side.
    assign aw_win = awvalid && (!arvalid || !prio_rd_q);
    assign ar_win = arvalid && (!awvalid ||  prio_rd_q);

    assign unused_bits = ^{awaddr[AXI_AW-1:SRAM_AW+4], awaddr[3:0],
                           araddr[AXI_AW-1:SRAM_AW+4], araddr[3:0], wlast};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            fixed_q   <= 1'b0;
            addr_q    <= '0;
            prio_rd_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            id_q      <= id_nxt;
            len_q     <= len_nxt;
            beat_q    <= beat_nxt;
            fixed_q   <= fixed_nxt;
            addr_q    <= addr_nxt;
            prio_rd_q <= prio_rd_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        id_nxt      = id_q;
        len_nxt     = len_q;
        beat_nxt    = beat_q;
        fixed_nxt   = fixed_q;
        addr_nxt    = addr_q;
        prio_rd_nxt = prio_rd_q;
        awready     = 1'b0;
        arready     = 1'b0;
        wready      = 1'b0;
        sram_cen    = 1'b1;
        sram_wen    = '1;
        sram_a      = addr_q;
        sram_d      = '0;

        case (state)
            IDLE: begin
                if (aw_win) begin
                    awready     = 1'b1;
                    id_nxt      = awid;
                    len_nxt     = awlen;
                    fixed_nxt   = (awburst == BURST_FIXED);
                    addr_nxt    = aw_word;
                    beat_nxt    = '0;
                    prio_rd_nxt = 1'b1;
                    state_nxt   = WR_DATA;
                end else if (ar_win) begin
                    // First read is issued on the grant so data is ready next cycle.
                    arready     = 1'b1;
                    id_nxt      = arid;
                    len_nxt     = arlen;
                    fixed_nxt   = (arburst == BURST_FIXED);
                    addr_nxt    = ar_word;
                    beat_nxt    = '0;
                    prio_rd_nxt = 1'b0;
                    sram_cen    = 1'b0;
                    sram_a      = ar_word;
                    state_nxt   = RD_DATA;
                end
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    sram_cen = 1'b0;
                    sram_wen = ~wstrb;
                    sram_d   = wdata;
                    addr_nxt = addr_step;
                    beat_nxt = beat_q + LEN_W'(1);
                    if (last_beat) begin
                        state_nxt = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_nxt = IDLE;
                end
            end
            RD_DATA: begin
                // Next read overlaps the current handshake to sustain one beat per cycle.
                if (rready) begin
                    if (last_beat) begin
                        state_nxt = IDLE;
                    end else begin
                        sram_cen = 1'b0;
                        sram_a   = addr_step;
                        addr_nxt = addr_step;
                        beat_nxt = beat_q + LEN_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bvalid = (state == WR_RESP);
    assign bid    = id_q;
    assign bresp  = RESP_OKAY;
    assign rvalid = (state == RD_DATA);
    assign rlast  = rvalid && last_beat;
    assign rid    = id_q;
    assign rresp  = RESP_OKAY;
    assign rdata  = sram_q;

endmodule

// File: tb/tb_axi_sram_ctrl128.sv
// Bench for axi_sram_ctrl128: random bursts against a word-array memory reference,
// with a behavioural SRAM macro on the memory port.
module tb_axi_sram_ctrl128;

    localparam int unsigned AXI_AW  = 40;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned SRAM_AW = 14;
    localparam int          WORDS   = 16384;

    logic                CLK;
    logic                RST_N;
    logic [ID_W-1:0]     awid;
    logic [AXI_AW-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [127:0]        wdata;
    logic [15:0]         wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [AXI_AW-1:0]   araddr;
    logic [7:0]          arlen;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [127:0]        rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [SRAM_AW-1:0]  sram_a;
    logic                sram_cen;
    logic [15:0]         sram_wen;
    logic [127:0]        sram_d;
    logic [127:0]        sram_q;

    logic [127:0] sram_mem [WORDS];
    logic [127:0] ref_mem  [WORDS];

    int n_chk;
    int n_fail;

    axi_sram_ctrl128 #(.AXI_AW(AXI_AW), .ID_W(ID_W), .SRAM_AW(SRAM_AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Macro model: byte writes, Q updated only by a pure read and held otherwise.
    always @(posedge CLK) begin
        if (sram_cen === 1'b0) begin
            for (int b = 0; b < 16; b++) begin
                if (!sram_wen[b]) sram_mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
            end
            if (&sram_wen) sram_q <= sram_mem[sram_a];
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int next_word(input int w, input logic [1:0] burst);
        return (burst == 2'b00) ? w : (w + 1) % WORDS;
    endfunction

    task automatic idle_inputs();
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b0; rready = 1'b0; awid = '0; arid = '0; awaddr = '0; araddr = '0;
        awlen = '0; arlen = '0; awburst = 2'b01; arburst = 2'b01; wdata = '0; wstrb = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_chk++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid,
             sram_cen, sram_wen} !== {6'b0, 4'b0, 8'h00, 1'b1, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL %s: aw/ar/w/b/r/rlast=%b%b%b%b%b%b bresp=%h rresp=%h bid=%h rid=%h cen=%b wen=%h required 000000 0 0 0 0 1 ffff",
                     tag, awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp,
                     bid, rid, sram_cen, sram_wen);
        end
    endtask

    // Entered at a negedge; returns at the negedge after the AW handshake.
    task automatic aw_phase(input logic [ID_W-1:0] id, input logic [AXI_AW-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int n;
        @(negedge CLK);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 50) begin
            @(negedge CLK); #1; n++;
        end
        n_chk++;
        if (awready !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_grant: awready=%b required 1", awready);
        end
        @(negedge CLK);
        awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [ID_W-1:0] id, input logic [AXI_AW-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int n;
        @(negedge CLK);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge CLK); #1; n++;
        end
        n_chk++;
        if (arready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_grant: arready=%b required 1", arready);
        end
        @(negedge CLK);
        arvalid = 1'b0;
    endtask

    // Data beats plus B response; strb_mode 0 = random strobes, 1 = fixed strobe.
    task automatic w_phase(input logic [ID_W-1:0] id, input int word, input logic [7:0] len,
                           input logic [1:0] burst, input bit strb_mode,
                           input logic [15:0] fstrb, input bit gaps);
        int w;
        int stall;
        logic [127:0] data;
        logic [15:0] strb;
        w = word;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    wvalid = 1'b0; #1;
                    n_chk++;
                    if (sram_cen !== 1'b1) begin
                        n_fail++;
                        $display("FAIL w_gap_cen: cen=%b required 1", sram_cen);
                    end
                    @(negedge CLK);
                end
            end
            data = rand128();
            strb = strb_mode ? fstrb : 16'($urandom);
            wdata = data; wstrb = strb; wvalid = 1'b1; wlast = (i == int'(len));
            #1;
            n_chk++;
            if ({wready, sram_cen, sram_a, sram_wen, sram_d} !== {1'b1, 1'b0, 14'(w), ~strb, data}) begin
                n_fail++;
                $display("FAIL w_beat%0d: wready=%b cen=%b a=%h wen=%h d=%h required 1 0 %h %h %h",
                         i, wready, sram_cen, sram_a, sram_wen, sram_d, 14'(w), ~strb, data);
            end
            for (int b = 0; b < 16; b++) begin
                if (strb[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
            end
            w = next_word(w, burst);
            @(negedge CLK);
        end
        wvalid = 1'b0; wlast = 1'b0;
        stall = $urandom_range(0, 2);
        for (int k = 0; k < stall; k++) begin
            #1;
            n_chk++;
            if (bvalid !== 1'b1 || sram_cen !== 1'b1) begin
                n_fail++;
                $display("FAIL b_hold: bvalid=%b cen=%b required 1 1", bvalid, sram_cen);
            end
            @(negedge CLK);
        end
        bready = 1'b1; #1;
        n_chk++;
        if ({bvalid, bid, bresp} !== {1'b1, id, 2'b00}) begin
            n_fail++;
            $display("FAIL b_resp: bvalid=%b bid=%h bresp=%h required 1 %h 0", bvalid, bid, bresp, id);
        end
        @(negedge CLK);
        bready = 1'b0; #1;
        n_chk++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b_drop: bvalid=%b required 0", bvalid);
        end
    endtask

    // stall_mode 0 = rready held high, 1 = toggled 1/0, 2 = random.
    task automatic r_phase(input logic [ID_W-1:0] id, input int word, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_mode);
        int w;
        int beat;
        int cyc;
        logic rr;
        w = word; beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 2000) begin
            case (stall_mode)
                1:       rr = (cyc % 2 == 0);
                2:       rr = 1'($urandom_range(0, 1));
                default: rr = 1'b1;
            endcase
            rready = rr; #1;
            n_chk++;
            if ({rvalid, rdata, rid, rresp, rlast} !== {1'b1, ref_mem[w], id, 2'b00, (beat == int'(len))}) begin
                n_fail++;
                $display("FAIL r_beat%0d: rvalid=%b rdata=%h rid=%h rresp=%h rlast=%b required 1 %h %h 0 %b",
                         beat, rvalid, rdata, rid, rresp, rlast, ref_mem[w], id, (beat == int'(len)));
            end
            if (!rr) begin
                n_chk++;
                if (sram_cen !== 1'b1) begin
                    n_fail++;
                    $display("FAIL r_stall_cen: cen=%b required 1", sram_cen);
                end
            end else begin
                beat++;
                w = next_word(w, burst);
            end
            @(negedge CLK);
            cyc++;
        end
        rready = 1'b0; #1;
        n_chk++;
        if (rvalid !== 1'b0 || beat != int'(len) + 1) begin
            n_fail++;
            $display("FAIL r_end: rvalid=%b beats=%0d required 0 %0d", rvalid, beat, int'(len) + 1);
        end
    endtask

    task automatic do_write(input logic [AXI_AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit strb_mode, input logic [15:0] fstrb);
        logic [ID_W-1:0] id;
        id = ID_W'($urandom);
        aw_phase(id, addr, len, burst);
        w_phase(id, int'(addr[17:4]), len, burst, strb_mode, fstrb, 1'b1);
    endtask

    task automatic do_read(input logic [AXI_AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_mode);
        logic [ID_W-1:0] id;
        id = ID_W'($urandom);
        ar_phase(id, addr, len, burst);
        r_phase(id, int'(addr[17:4]), len, burst, stall_mode);
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("reset_values");
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_arbitration();
        @(negedge CLK);
        awid = 4'h3; awaddr = 40'h100; awlen = 8'd1; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'h9; araddr = 40'h200; arlen = 8'd1; arburst = 2'b01; arvalid = 1'b1;
        #1;
        n_chk++;
        if ({awready, arready} !== 2'b10) begin
            n_fail++;
            $display("FAIL arb_first: awready=%b arready=%b required 1 0", awready, arready);
        end
        @(negedge CLK);
        awvalid = 1'b0; #1;
        n_chk++;
        if (arready !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_busy: arready=%b required 0", arready);
        end
        w_phase(4'h3, 16, 8'd1, 2'b01, 1'b0, 16'h0, 1'b0);
        awvalid = 1'b1; #1;
        n_chk++;
        if ({awready, arready} !== 2'b01) begin
            n_fail++;
            $display("FAIL arb_second: awready=%b arready=%b required 0 1", awready, arready);
        end
        @(negedge CLK);
        awvalid = 1'b0; arvalid = 1'b0;
        r_phase(4'h9, 32, 8'd1, 2'b01, 0);
    endtask

    task automatic test_single_write();
        do_write(40'h40, 8'd0, 2'b01, 1'b1, 16'hFFFF);
        do_read(40'h40, 8'd0, 2'b01, 0);
    endtask

    task automatic test_wrap();
        do_write(40'h3FFF0, 8'd3, 2'b01, 1'b0, 16'h0);
        do_read(40'h3FFF0, 8'd3, 2'b01, 0);
        do_write(40'hFF_0003_FFF5, 8'd2, 2'b10, 1'b1, 16'hFFFF);
        do_read(40'h3FFF0, 8'd2, 2'b10, 2);
    endtask

    task automatic test_read_stall();
        do_read(40'h1230, 8'd7, 2'b01, 1);
        do_read(40'h1230, 8'd7, 2'b01, 0);
        do_read(40'h5550, 8'd4, 2'b00, 2);
    endtask

    task automatic test_partial_strobe();
        do_write(40'h8000, 8'd0, 2'b01, 1'b1, 16'hFFFF);
        do_write(40'h8000, 8'd0, 2'b01, 1'b1, 16'h000F);
        do_read(40'h8000, 8'd0, 2'b01, 0);
        do_write(40'h8010, 8'd1, 2'b00, 1'b1, 16'h0000);
        do_read(40'h8010, 8'd0, 2'b01, 0);
    endtask

    task automatic test_random();
        logic [AXI_AW-1:0] addr;
        logic [7:0] len;
        logic [1:0] burst;
        for (int i = 0; i < 24; i++) begin
            addr  = AXI_AW'({$urandom, $urandom});
            len   = 8'($urandom_range(0, 9));
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) do_write(addr, len, burst, 1'b0, 16'h0);
            else                           do_read(addr, len, burst, 2);
        end
    endtask

    task automatic test_reset_mid_burst();
        ar_phase(4'h5, 40'h2000, 8'd7, 2'b01);
        rready = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        rready = 1'b0;
        #1;
        check_reset_outputs("reset_mid_burst");
        @(negedge CLK); #1;
        check_reset_outputs("reset_hold");
        @(negedge CLK);
        RST_N = 1'b1;
        do_write(40'h2000, 8'd1, 2'b01, 1'b0, 16'h0);
        do_read(40'h2000, 8'd1, 2'b01, 0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = rand128();
            ref_mem[i]  = sram_mem[i];
        end
        sram_q = '0;
        test_reset();
        test_arbitration();
        test_single_write();
        test_wrap();
        test_read_stall();
        test_partial_strobe();
        test_random();
        test_reset_mid_burst();
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
